// File: rtl/sha3_digest_streamer.sv
// Output stage after the Keccak permutation: captures the state truncated to the
// digest length and streams it as an AXI-Stream master, lane 0 byte 0 first.
module sha3_digest_streamer #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIGEST_BITS = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [4:0][4:0][63:0]   state_in,
  input  logic                    state_valid,
  output logic [DATA_WIDTH-1:0]   M_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_TKEEP,
  output logic                    M_TVALID,
  output logic                    M_TLAST,
  input  logic                    M_TREADY,
  output logic                    busy,
  output logic                    overrun
);
  localparam int BEATS = DIGEST_BITS / DATA_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DIGEST_BITS-1:0] shift_q, shift_d;
  logic                   last_q, last_d;
  logic                   overrun_q, overrun_d;
  logic [1599:0]          lanes;
  logic                   unused_lanes;
  logic                   fire;
  logic                   at_last;
  logic                   recapture;

  // Lane i = x + 5*y laid out little-endian, so bit 8*k of this vector starts digest byte k.
  always_comb begin
    lanes = '0;
    for (int i = 0; i < 25; i++) lanes[64*i +: 64] = state_in[i % 5][i / 5];
  end

  assign unused_lanes = ^lanes[1599:DIGEST_BITS];

  assign fire      = (state_q == SEND) && M_TREADY;
  assign at_last   = (cnt_q == LAST_CNT);
  assign recapture = state_valid && ((state_q == IDLE) || (fire && at_last));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    last_d    = last_q;
    overrun_d = overrun_q || (state_valid && !recapture);
    if (recapture) begin
      state_d = SEND;
      cnt_d   = '0;
      shift_d = lanes[DIGEST_BITS-1:0];
      last_d  = (BEATS == 1);
    end else if (fire) begin
      shift_d = shift_q >> DATA_WIDTH;
      if (at_last) begin
        state_d = IDLE;
        cnt_d   = '0;
        last_d  = 1'b0;
      end else begin
        cnt_d  = cnt_q + CW'(1);
        last_d = ((cnt_q + CW'(1)) == LAST_CNT);
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  assign M_TDATA  = shift_q[DATA_WIDTH-1:0];
  assign M_TKEEP  = '1;
  assign M_TVALID = (state_q == SEND);
  assign M_TLAST  = last_q;
  assign busy     = (state_q == SEND);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_sha3_digest_streamer.sv
// Bench for sha3_digest_streamer: a 256-bit and a 512-bit instance checked every
// cycle against a byte-level queue model of the digest stream.
module tb_sha3_digest_streamer;
  typedef logic [4:0][4:0][63:0] kstate_t;
  typedef struct { logic [15:0] data; logic last; } beat_t;
  typedef struct { int beat; logic [15:0] data; logic last; } vec_t;

  logic        ACLK = 1'b0;
  logic        ARESET;
  kstate_t     st_a, st_b;
  logic        sv_a, sv_b, rdy_a, rdy_b;
  logic [15:0] tdata_a, tdata_b;
  logic [1:0]  tkeep_a, tkeep_b;
  logic        tvalid_a, tvalid_b, tlast_a, tlast_b;
  logic        busy_a, busy_b, ovr_a, ovr_b;

  always #5 ACLK = ~ACLK;

  sha3_digest_streamer #(.DATA_WIDTH(16), .DIGEST_BITS(256)) dut_a (
    .ACLK(ACLK), .ARESET(ARESET), .state_in(st_a), .state_valid(sv_a),
    .M_TDATA(tdata_a), .M_TKEEP(tkeep_a), .M_TVALID(tvalid_a), .M_TLAST(tlast_a),
    .M_TREADY(rdy_a), .busy(busy_a), .overrun(ovr_a));

  sha3_digest_streamer #(.DATA_WIDTH(16), .DIGEST_BITS(512)) dut_b (
    .ACLK(ACLK), .ARESET(ARESET), .state_in(st_b), .state_valid(sv_b),
    .M_TDATA(tdata_b), .M_TKEEP(tkeep_b), .M_TVALID(tvalid_b), .M_TLAST(tlast_b),
    .M_TREADY(rdy_b), .busy(busy_b), .overrun(ovr_b));

  int          checks = 0;
  int          errors = 0;
  beat_t       exp_a[$], exp_b[$];
  bit          ov_a, ov_b;
  logic [15:0] obs_a[$], obs_b[$];
  logic        obs_last_a[$];
  int          lasts_a, lasts_b, last_idx_b;
  bit          stall_a, stall_b;
  logic [15:0] stall_data_a, stall_data_b;
  logic        stall_last_a, stall_last_b;
  logic [15:0] basic_beats[$];
  kstate_t     sha_state, other_state, st512;
  vec_t        vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic kstate_t rand_state();
    kstate_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) s[x][y] = {$urandom, $urandom};
    return s;
  endfunction

  function automatic logic [7:0] digest_byte(input kstate_t s, input int k);
    int lane;
    int b;
    lane = k / 8;
    b    = k % 8;
    return s[lane % 5][lane / 5][8*b +: 8];
  endfunction

  task automatic push_digest(input bit to_b, input kstate_t s);
    beat_t bt;
    int    nbeats;
    nbeats = to_b ? 32 : 16;
    for (int w = 0; w < nbeats; w++) begin
      bt.data = {digest_byte(s, 2*w + 1), digest_byte(s, 2*w)};
      bt.last = (w == nbeats - 1);
      if (to_b) exp_b.push_back(bt);
      else      exp_a.push_back(bt);
    end
  endtask

  task automatic check_side(input string tag, input logic valid, input logic [15:0] data,
                            input logic last, input logic bsy, input logic ovr,
                            input logic [1:0] keep, input bit has_exp, input beat_t front,
                            input bit exp_ov, input bit stalled, input logic [15:0] s_data,
                            input logic s_last);
    check({tag, "_keep"}, keep, 2'b11);
    check({tag, "_valid"}, valid, has_exp);
    check({tag, "_busy"}, bsy, has_exp);
    check({tag, "_overrun"}, ovr, exp_ov);
    if (has_exp) begin
      check({tag, "_data"}, data, front.data);
      check({tag, "_last"}, last, front.last);
    end
    if (stalled) begin
      check({tag, "_stall_valid"}, valid, 1'b1);
      check({tag, "_stall_data"}, data, s_data);
      check({tag, "_stall_last"}, last, s_last);
    end
  endtask

  task automatic checkOutput();
    beat_t fa, fb;
    fa.data = '0; fa.last = 1'b0;
    fb.data = '0; fb.last = 1'b0;
    if (exp_a.size() > 0) fa = exp_a[0];
    if (exp_b.size() > 0) fb = exp_b[0];
    check_side("a", tvalid_a, tdata_a, tlast_a, busy_a, ovr_a, tkeep_a, exp_a.size() > 0, fa,
               ov_a, stall_a, stall_data_a, stall_last_a);
    check_side("b", tvalid_b, tdata_b, tlast_b, busy_b, ovr_b, tkeep_b, exp_b.size() > 0, fb,
               ov_b, stall_b, stall_data_b, stall_last_b);
  endtask

  // One cycle: check what the DUTs show, advance the model, drive the next inputs.
  task automatic applyStimulus(input bit ra, input bit va, input kstate_t na,
                               input bit rb, input bit vb, input kstate_t nb);
    bit m_hs, accept;
    @(negedge ACLK);
    checkOutput();

    if (tvalid_a && ra) begin
      obs_a.push_back(tdata_a);
      obs_last_a.push_back(tlast_a);
      if (tlast_a) lasts_a++;
    end
    m_hs   = (exp_a.size() > 0) && ra;
    accept = va && ((exp_a.size() == 0) || ((exp_a.size() == 1) && m_hs));
    if (va && !accept) ov_a = 1'b1;
    if (m_hs) void'(exp_a.pop_front());
    if (accept) push_digest(1'b0, na);
    stall_a      = tvalid_a && !ra;
    stall_data_a = tdata_a;
    stall_last_a = tlast_a;

    if (tvalid_b && rb) begin
      obs_b.push_back(tdata_b);
      if (tlast_b) begin
        lasts_b++;
        last_idx_b = obs_b.size() - 1;
      end
    end
    m_hs   = (exp_b.size() > 0) && rb;
    accept = vb && ((exp_b.size() == 0) || ((exp_b.size() == 1) && m_hs));
    if (vb && !accept) ov_b = 1'b1;
    if (m_hs) void'(exp_b.pop_front());
    if (accept) push_digest(1'b1, nb);
    stall_b      = tvalid_b && !rb;
    stall_data_b = tdata_b;
    stall_last_b = tlast_b;

    rdy_a = ra; sv_a = va; st_a = na;
    rdy_b = rb; sv_b = vb; st_b = nb;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_a_valid"}, tvalid_a, 1'b0);
    check({tag, "_a_last"}, tlast_a, 1'b0);
    check({tag, "_a_data"}, tdata_a, 16'h0);
    check({tag, "_a_busy"}, busy_a, 1'b0);
    check({tag, "_a_overrun"}, ovr_a, 1'b0);
    check({tag, "_a_keep"}, tkeep_a, 2'b11);
    check({tag, "_b_valid"}, tvalid_b, 1'b0);
    check({tag, "_b_last"}, tlast_b, 1'b0);
    check({tag, "_b_data"}, tdata_b, 16'h0);
    check({tag, "_b_overrun"}, ovr_b, 1'b0);
  endtask

  task automatic async_reset();
    @(posedge ACLK);
    #2;
    ARESET = 1'b1;
    #1;
    check_reset_values("async_rst");
    exp_a.delete(); exp_b.delete();
    ov_a = 1'b0; ov_b = 1'b0;
    stall_a = 1'b0; stall_b = 1'b0;
    sv_a = 1'b0; sv_b = 1'b0;
    repeat (2) begin
      @(negedge ACLK);
      check("rst_hold_a_valid", tvalid_a, 1'b0);
      check("rst_hold_b_valid", tvalid_b, 1'b0);
    end
    ARESET = 1'b0;
  endtask

  task automatic clear_obs();
    obs_a.delete(); obs_last_a.delete(); obs_b.delete();
    lasts_a = 0; lasts_b = 0; last_idx_b = -1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, st_a, 1'b1, 1'b0, st_b);
  endtask

  function automatic logic [15:0] obs_at(input int idx);
    logic [15:0] v;
    v = 16'hxxxx;
    if (idx < obs_a.size()) v = obs_a[idx];
    return v;
  endfunction

  function automatic bit ready30();
    return ($urandom_range(0, 9) < 3);
  endfunction

  initial begin
    vecs[0] = '{0,  16'hffa7, 1'b0};
    vecs[1] = '{1,  16'hf8c6, 1'b0};
    vecs[2] = '{2,  16'h1ebf, 1'b0};
    vecs[3] = '{3,  16'h66d7, 1'b0};
    vecs[4] = '{4,  16'hc151, 1'b0};
    vecs[5] = '{7,  16'h62d6, 1'b0};
    vecs[6] = '{14, 16'hf880, 1'b0};
    vecs[7] = '{15, 16'h4a43, 1'b1};

    // SHA3-256("") digest in lanes 0..3; other lanes are junk that must be truncated away.
    sha_state       = rand_state();
    sha_state[0][0] = 64'h66d71ebff8c6ffa7;
    sha_state[1][0] = 64'h62d661a05647c151;
    sha_state[2][0] = 64'hfa493be44dff80f5;
    sha_state[3][0] = 64'h4a43f8804b0ad882;
    other_state     = rand_state();
    st512           = rand_state();

    ARESET = 1'b1;
    rdy_a = 1'b0; rdy_b = 1'b0; sv_a = 1'b0; sv_b = 1'b0; st_a = '0; st_b = '0;
    ov_a = 1'b0; ov_b = 1'b0; stall_a = 1'b0; stall_b = 1'b0;
    clear_obs();
    repeat (2) @(negedge ACLK);
    check_reset_values("init");
    ARESET = 1'b0;

    $display("[TB] basic SHA3-256 stream");
    clear_obs();
    applyStimulus(1'b1, 1'b1, sha_state, 1'b1, 1'b0, st_b);
    idle_cycles(20);
    check("basic_beats", obs_a.size(), 16);
    check("basic_lasts", lasts_a, 1);
    basic_beats = obs_a;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("vec_beat%0d_data", vecs[i].beat), obs_at(vecs[i].beat), vecs[i].data);
      check($sformatf("vec_beat%0d_last", vecs[i].beat),
            (vecs[i].beat < obs_last_a.size()) ? obs_last_a[vecs[i].beat] : 1'bx, vecs[i].last);
    end

    $display("[TB] backpressure 30 percent ready");
    clear_obs();
    applyStimulus(ready30(), 1'b1, sha_state, 1'b1, 1'b0, st_b);
    for (int i = 0; i < 400 && !(obs_a.size() == 16 && exp_a.size() == 0); i++)
      applyStimulus(ready30(), 1'b0, sha_state, 1'b1, 1'b0, st_b);
    idle_cycles(2);
    check("bp_beats", obs_a.size(), 16);
    check("bp_lasts", lasts_a, 1);
    for (int i = 0; i < 16; i++) check($sformatf("bp_beat%0d", i), obs_at(i), basic_beats[i]);

    $display("[TB] overrun during stream");
    clear_obs();
    applyStimulus(1'b1, 1'b1, sha_state, 1'b1, 1'b0, st_b);
    for (int j = 0; j < 24; j++) applyStimulus(1'b1, j == 5, other_state, 1'b1, 1'b0, st_b);
    check("ovr_beats", obs_a.size(), 16);
    for (int i = 0; i < 16; i++) check($sformatf("ovr_beat%0d", i), obs_at(i), basic_beats[i]);
    check("ovr_sticky", ovr_a, 1'b1);
    async_reset();

    $display("[TB] back-to-back digests");
    clear_obs();
    applyStimulus(1'b1, 1'b1, sha_state, 1'b1, 1'b0, st_b);
    for (int j = 0; j < 32; j++) applyStimulus(1'b1, j == 15, other_state, 1'b1, 1'b0, st_b);
    check("b2b_no_gap_beats", obs_a.size(), 32);
    idle_cycles(3);
    check("b2b_lasts", lasts_a, 2);
    check("b2b_overrun", ovr_a, 1'b0);
    check("b2b_first_of_second", obs_at(16),
          {digest_byte(other_state, 1), digest_byte(other_state, 0)});
    check("b2b_first_of_first", obs_at(0), 16'hffa7);

    $display("[TB] reset mid-stream");
    clear_obs();
    applyStimulus(1'b1, 1'b1, sha_state, 1'b1, 1'b0, st_b);
    for (int j = 0; j < 8; j++) applyStimulus(1'b1, 1'b0, sha_state, 1'b1, 1'b0, st_b);
    async_reset();
    check("rst_no_partial_last", lasts_a, 0);
    clear_obs();
    applyStimulus(1'b1, 1'b1, sha_state, 1'b1, 1'b0, st_b);
    idle_cycles(20);
    check("rst_restart_beats", obs_a.size(), 16);
    check("rst_restart_beat0", obs_at(0), 16'hffa7);
    check("rst_restart_lasts", lasts_a, 1);

    $display("[TB] 512-bit digest");
    clear_obs();
    applyStimulus(1'b1, 1'b0, sha_state, 1'b1, 1'b1, st512);
    for (int j = 0; j < 36; j++) applyStimulus(1'b1, 1'b0, sha_state, 1'b1, 1'b0, st512);
    check("d512_beats", obs_b.size(), 32);
    check("d512_lasts", lasts_b, 1);
    check("d512_last_idx", last_idx_b, 31);
    check("d512_beat4", (obs_b.size() > 4) ? obs_b[4] : 16'hxxxx, st512[1][0][15:0]);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++)
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 19) == 0, rand_state(),
                    ready30(), $urandom_range(0, 24) == 0, rand_state());
    async_reset();
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
